// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential instruction fetch stage in front of the decoder.
// Issues in-order instruction-memory reads, counts outstanding requests and
// buffers returned words with their addresses in a small prefetch FIFO. A
// redirect flushes the FIFO, retargets fetch, and marks every request still in
// flight as stale so its response is dropped on return.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid never depends on ready on the same interface. The memory
// response channel has no ready: every imem_resp_valid cycle is one returned
// word, in request order.
module instruction_fetch #(
    parameter int INST_W          = 16,
    parameter int I_ADDR_W        = 12,
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [I_ADDR_W-1:0] redirect_address,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [I_ADDR_W-1:0] imem_req_address,
    input  logic                imem_resp_valid,
    input  logic [INST_W-1:0]   imem_resp_data,
    output logic                instruction_valid,
    input  logic                instruction_ready,
    output logic [INST_W-1:0]   instruction,
    output logic [I_ADDR_W-1:0] instruction_address,
    output logic                o_dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
    localparam int ENT_W = I_ADDR_W + INST_W;

    // FETCH: no stale responses pending. DRAIN: at least one stale response
    // is still owed by the memory and will be dropped on arrival.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Fetch bookkeeping
    logic [I_ADDR_W-1:0] r_fetch_address;
    logic [I_ADDR_W-1:0] r_resp_address;
    logic [OUT_W-1:0]    r_inflight;
    logic [OUT_W-1:0]    r_discard;
    logic [OUT_W-1:0]    w_inflight_next;
    logic [OUT_W-1:0]    w_discard_next;
    logic [OUT_W-1:0]    w_redirect_discard;
    logic [OUT_W-1:0]    w_live;

    // Prefetch FIFO
    logic [ENT_W-1:0]    r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ENT_W-1:0]    w_head;

    // Handshake and credit terms
    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_credit_ok;
    logic                w_slot_ok;
    logic                w_req_fire;
    logic                w_drop;
    logic                w_push;
    logic                w_pop;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------

    // Live requests will land in the FIFO, so they reserve a slot now.
    assign w_live       = r_inflight - r_discard;
    assign w_credit_sum = SUM_W'(r_count) + SUM_W'(w_live);
    assign w_credit_ok  = w_credit_sum < SUM_W'(FIFO_DEPTH);
    assign w_slot_ok    = r_inflight < OUT_W'(MAX_OUTSTANDING);

    // Gated by reset so the request output is quiet while held in reset.
    assign imem_req_valid   = !reset && !redirect_valid && w_credit_ok && w_slot_ok;
    assign imem_req_address = r_fetch_address;
    assign w_req_fire       = imem_req_valid && imem_req_ready;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------

    // A response in a redirect cycle is never pushed: it belongs to the old
    // stream whether or not it was already counted as stale.
    assign w_drop = imem_resp_valid && (r_discard != '0);
    assign w_push = imem_resp_valid && (r_discard == '0) && !redirect_valid;

    // ------------------------------------------------------------------
    // Downstream side
    // ------------------------------------------------------------------

    assign instruction_valid   = (r_count != '0);
    assign w_pop               = instruction_valid && instruction_ready && !redirect_valid;
    assign w_head              = r_fifo_mem[r_rd_ptr];
    assign instruction         = instruction_valid ? w_head[INST_W-1:0] : '0;
    assign instruction_address = instruction_valid ? w_head[ENT_W-1:INST_W] : '0;

    assign o_dbg_state = r_state;

    // Everything still in flight at a redirect is stale, except the response
    // arriving that same cycle, which is consumed (and dropped) right away.
    assign w_redirect_discard = imem_resp_valid ? (r_inflight - OUT_W'(1)) : r_inflight;

    // Outstanding count: +1 per accepted request, -1 per returned response.
    always_comb begin
        w_inflight_next = r_inflight;
        if (w_req_fire && !imem_resp_valid) begin
            w_inflight_next = r_inflight + OUT_W'(1);
        end else if (!w_req_fire && imem_resp_valid) begin
            w_inflight_next = r_inflight - OUT_W'(1);
        end
    end

    // Next state and stale-response counter; redirect overrides draining.
    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        case (r_state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    w_discard_next = w_redirect_discard;
                    if (w_redirect_discard != '0) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    w_discard_next = w_redirect_discard;
                    w_state_next   = (w_redirect_discard != '0) ? ST_DRAIN : ST_FETCH;
                end else if (w_drop) begin
                    w_discard_next = r_discard - OUT_W'(1);
                    if (r_discard == OUT_W'(1)) begin
                        w_state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_next   = ST_FETCH;
                w_discard_next = '0;
            end
        endcase
    end

    // State register plus request/response counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_inflight_next;
            r_discard  <= w_discard_next;
        end
    end

    // Fetch and response address pointers; both jump to the redirect target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_address <= '0;
            r_resp_address  <= '0;
        end else if (redirect_valid) begin
            r_fetch_address <= redirect_address;
            r_resp_address  <= redirect_address;
        end else begin
            if (w_req_fire) begin
                r_fetch_address <= r_fetch_address + I_ADDR_W'(1);
            end
            if (w_push) begin
                r_resp_address <= r_resp_address + I_ADDR_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observed when the count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_resp_address, imem_resp_data};
        end
    end

    // The credit check at request time must make overflow impossible.
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));

    // Responses only ever answer requests this block issued.
    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (r_inflight != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: drives instruction_fetch with an in-order memory model
// of configurable latency and a consumer with configurable readiness. Every
// memory response that should survive is pushed to an expected queue and
// compared when the stage hands the instruction downstream.
module tb_instruction_fetch;

    localparam int INST_W          = 16;
    localparam int I_ADDR_W        = 12;
    localparam int FIFO_DEPTH      = 2;
    localparam int MAX_OUTSTANDING = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                redirect_valid;
    logic [I_ADDR_W-1:0] redirect_address;
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [I_ADDR_W-1:0] imem_req_address;
    logic                imem_resp_valid;
    logic [INST_W-1:0]   imem_resp_data;
    logic                instruction_valid;
    logic                instruction_ready;
    logic [INST_W-1:0]   instruction;
    logic [I_ADDR_W-1:0] instruction_address;
    logic                o_dbg_state;

    instruction_fetch #(
        .INST_W          (INST_W),
        .I_ADDR_W        (I_ADDR_W),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .imem_req_valid      (imem_req_valid),
        .imem_req_ready      (imem_req_ready),
        .imem_req_address    (imem_req_address),
        .imem_resp_valid     (imem_resp_valid),
        .imem_resp_data      (imem_resp_data),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready),
        .instruction         (instruction),
        .instruction_address (instruction_address),
        .o_dbg_state         (o_dbg_state)
    );

    // ---------------- memory model / scoreboard ----------------
    typedef struct {
        logic [I_ADDR_W-1:0] addr;
        int                  due;
        bit                  stale;
    } mem_req_t;

    mem_req_t                   pipe[$];
    logic [I_ADDR_W+INST_W-1:0] exp_q[$];

    int                  n_checks;
    int                  n_fail;
    int                  cyc;
    int                  mem_lat;
    int                  inst_rdy_mode;   // 0 low, 1 high, 2 random
    bit                  req_rdy_rand;
    logic [I_ADDR_W-1:0] exp_fetch;
    int                  n_req_fired;
    int                  n_delivered;
    logic [I_ADDR_W-1:0] last_del_addr;
    logic [INST_W-1:0]   last_del_data;
    bit                  have_last;
    bit                  wrap_seen;
    logic [I_ADDR_W-1:0] last_req_addr;
    bit                  have_last_req;
    bit                  req_wrap_seen;
    logic                last_req_valid;

    function automatic logic [INST_W-1:0] mem_word(input logic [I_ADDR_W-1:0] a);
        return {a[3:0], a} ^ 16'h5A3C;
    endfunction

    function automatic bit head_due();
        return (pipe.size() > 0) && (pipe[0].due <= cyc);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: entered and left 1ns after a rising edge.
    task automatic run_cycle(input bit redir, input logic [I_ADDR_W-1:0] raddr);
        int                         stale_cnt;
        bit                         presenting;
        mem_req_t                   r;
        logic [I_ADDR_W+INST_W-1:0] e;

        stale_cnt = 0;
        foreach (pipe[i]) if (pipe[i].stale) stale_cnt++;
        check_eq("state", o_dbg_state, (stale_cnt != 0));

        presenting      = head_due();
        imem_resp_valid = presenting;
        imem_resp_data  = presenting ? mem_word(pipe[0].addr) : '0;
        imem_req_ready  = req_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        case (inst_rdy_mode)
            0:       instruction_ready = 1'b0;
            1:       instruction_ready = 1'b1;
            default: instruction_ready = 1'($urandom_range(0, 1));
        endcase
        redirect_valid   = redir;
        redirect_address = raddr;
        if (redir) foreach (pipe[i]) pipe[i].stale = 1'b1;

        @(negedge clk);
        last_req_valid = imem_req_valid;
        if (redir) check_eq("req_valid_in_redirect", imem_req_valid, 1'b0);
        check_eq("inst_valid", instruction_valid, (exp_q.size() != 0));
        if (!instruction_valid) begin
            check_eq("idle_instruction", instruction, '0);
            check_eq("idle_inst_addr", instruction_address, '0);
        end
        if (!redir && instruction_valid && instruction_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("inst_data", instruction, e[INST_W-1:0]);
            check_eq("inst_addr", instruction_address, e[I_ADDR_W+INST_W-1:INST_W]);
            if (have_last && last_del_addr == 12'hFFF && instruction_address == 12'h000)
                wrap_seen = 1'b1;
            last_del_addr = instruction_address;
            last_del_data = instruction;
            have_last     = 1'b1;
            n_delivered++;
        end
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_address, exp_fetch);
            if (have_last_req && last_req_addr == 12'hFFF && imem_req_address == 12'h000)
                req_wrap_seen = 1'b1;
            last_req_addr = imem_req_address;
            have_last_req = 1'b1;
            r.addr  = imem_req_address;
            r.due   = cyc + mem_lat;
            r.stale = 1'b0;
            pipe.push_back(r);
            exp_fetch = exp_fetch + 12'd1;
            n_req_fired++;
        end
        if (presenting) begin
            if (!pipe[0].stale) exp_q.push_back({pipe[0].addr, mem_word(pipe[0].addr)});
            void'(pipe.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            exp_fetch = raddr;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset immediately (mid-cycle if called mid-stream), checks the
    // outputs cleared before any edge, then releases and checks the restart.
    task automatic apply_reset();
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        redirect_address  = '0;
        imem_req_ready    = 1'b0;
        imem_resp_valid   = 1'b0;
        imem_resp_data    = '0;
        instruction_ready = 1'b0;
        pipe.delete();
        exp_q.delete();
        exp_fetch     = '0;
        n_req_fired   = 0;
        n_delivered   = 0;
        have_last     = 1'b0;
        have_last_req = 1'b0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_req_addr", imem_req_address, '0);
        check_eq("rst_inst_valid", instruction_valid, 1'b0);
        check_eq("rst_instruction", instruction, '0);
        check_eq("rst_inst_addr", instruction_address, '0);
        check_eq("rst_state", o_dbg_state, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cyc   = cyc + 2;
        reset = 1'b0;
        #1;
        check_eq("first_req_valid", imem_req_valid, 1'b1);
        check_eq("first_req_addr", imem_req_address, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int d0;
        int n_infl;

        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        mem_lat       = 1;
        inst_rdy_mode = 1;
        req_rdy_rand  = 1'b0;
        wrap_seen     = 1'b0;
        req_wrap_seen = 1'b0;
        apply_reset();

        // Streaming with a 1-cycle memory and an always-ready consumer.
        repeat (40) run_cycle(1'b0, '0);
        check_eq("stream_progress", (n_delivered >= 20), 1'b1);

        // Consumer stalls: the buffer fills and requests stop.
        inst_rdy_mode = 0;
        repeat (12) run_cycle(1'b0, '0);
        check_eq("stall_req_valid", last_req_valid, 1'b0);
        check_eq("stall_inst_valid", instruction_valid, 1'b1);
        check_eq("stall_buffered", n_req_fired - n_delivered, FIFO_DEPTH);

        // Release, stream again, then stall to full before an async reset.
        inst_rdy_mode = 1;
        repeat (20) run_cycle(1'b0, '0);
        inst_rdy_mode = 0;
        repeat (10) run_cycle(1'b0, '0);
        check_eq("pre_reset_full", instruction_valid, 1'b1);
        apply_reset();

        // Stale requests: with a 5-cycle memory, redirect twice so three
        // requests are outstanding when the second redirect lands.
        mem_lat       = 5;
        inst_rdy_mode = 1;
        k = 0;
        while (!(pipe.size() == 2 && !head_due()) && k < 20) begin
            run_cycle(1'b0, '0);
            k++;
        end
        check_eq("drain_setup_a", (k < 20), 1'b1);
        run_cycle(1'b1, 12'h080);
        k = 0;
        while (!(pipe.size() == 3 && !head_due()) && k < 20) begin
            run_cycle(1'b0, '0);
            k++;
        end
        check_eq("drain_setup_b", (k < 20), 1'b1);
        run_cycle(1'b1, 12'h100);
        check_eq("drain_entered", o_dbg_state, 1'b1);
        d0 = n_delivered;
        k  = 0;
        while (n_delivered == d0 && k < 40) begin
            run_cycle(1'b0, '0);
            k++;
        end
        check_eq("drain_deliver_timeout", (k < 40), 1'b1);
        check_eq("drain_first_addr", last_del_addr, 12'h100);
        check_eq("drain_first_data", last_del_data, mem_word(12'h100));
        check_eq("drain_exit_state", o_dbg_state, 1'b0);

        // Redirect in the same cycle as a response arrival and a pop.
        mem_lat = 1;
        k = 0;
        while (!(head_due() && exp_q.size() != 0) && k < 40) begin
            run_cycle(1'b0, '0);
            k++;
        end
        check_eq("redir_resp_setup", (k < 40), 1'b1);
        n_infl = pipe.size();
        run_cycle(1'b1, 12'h200);
        check_eq("redir_resp_fifo_empty", instruction_valid, 1'b0);
        check_eq("redir_resp_discard", o_dbg_state, ((n_infl - 1) != 0));
        d0 = n_delivered;
        k  = 0;
        while (n_delivered == d0 && k < 40) begin
            run_cycle(1'b0, '0);
            k++;
        end
        check_eq("redir_resp_first_addr", last_del_addr, 12'h200);

        // Address wrap at the top of the instruction space.
        run_cycle(1'b1, 12'hFFD);
        repeat (20) run_cycle(1'b0, '0);
        check_eq("req_addr_wrap", req_wrap_seen, 1'b1);
        check_eq("inst_addr_wrap", wrap_seen, 1'b1);

        // Random traffic: latency, both readies and redirects vary.
        mem_lat       = $urandom_range(1, 3);
        req_rdy_rand  = 1'b1;
        inst_rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0)
                run_cycle(1'b1, 12'($urandom_range(0, 4095)));
            else
                run_cycle(1'b0, '0);
        end
        req_rdy_rand  = 1'b0;
        inst_rdy_mode = 1;
        repeat (20) run_cycle(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
